// File: rtl/sha3_pkg.sv
// sha3_pkg
// Shared constants and types for the SHA3-512 absorber/padder.
//   STATE_W             : width of the full Keccak state block (1600)
//   LANE_W              : lane width (64)
//   SHA3_512_RATE_LANES : rate lanes for SHA3-512 (9 lanes = 576 bits)
//   PAD_END             : closing pad10*1 bit, placed at the top of the last rate byte
//   DOMAIN_BYTE         : domain suffix byte with the first pad bit folded in
//   pad_state_t         : padder FSM states
// Build option: SHA3_KECCAK_PAD_EN selects original Keccak padding (0x01)
// instead of FIPS 202 SHA-3 padding (0x06).
package sha3_pkg;

    localparam int STATE_W             = 1600;
    localparam int LANE_W              = 64;
    localparam int SHA3_512_RATE_LANES = 9;
    localparam logic [7:0] PAD_END     = 8'h80;

`ifdef SHA3_KECCAK_PAD_EN
    localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`else
    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`endif

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        PADX = 2'd2
    } pad_state_t;

endpackage

// File: rtl/sha3_pad_lane.sv
// sha3_pad_lane
// Combinational pad of one incoming 64-bit message lane.
//   lane       : raw message word, byte j at [8j+7:8j]
//   nbytes     : valid byte count, already clamped to 0..8
//   last       : word is the final word of the message
//   final_lane : word lands in the last rate lane of the block
//   padded     : lane with bytes >= nbytes cleared, the domain byte at
//                offset nbytes, and PAD_END in byte 7 when the final lane
//                also closes the block. Non-last words pass through unchanged.
// Build option: SHA3_KECCAK_PAD_EN (through sha3_pkg::DOMAIN_BYTE).
module sha3_pad_lane
    import sha3_pkg::*;
(
    input  logic [63:0] lane,
    input  logic [3:0]  nbytes,
    input  logic        last,
    input  logic        final_lane,
    output logic [63:0] padded
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte
            logic keep;
            logic dom_here;
            logic end_here;

            assign keep     = !last || (4'(gi) < nbytes);
            assign dom_here = last && (4'(gi) == nbytes);
            // A full final word at the last lane leaves no room for padding;
            // the top level emits a separate pad-only block for that case.
            assign end_here = last && final_lane && (gi == 7) && (nbytes < 4'd8);

            assign padded[8*gi +: 8] = (keep     ? lane[8*gi +: 8] : 8'h00)
                                     ^ (dom_here ? DOMAIN_BYTE     : 8'h00)
                                     ^ (end_here ? PAD_END         : 8'h00);
        end
    endgenerate

endmodule

// File: rtl/sha3_padder.sv
// sha3_padder
// Absorbs a little-endian 64-bit word stream into rate blocks, applies the
// SHA-3 pad10*1 rule with the domain suffix and presents each block as a full
// 1600-bit state (zero capacity) to the permutation.
//   inClk, inRstN           : clock, asynchronous active-low reset
//   inData/inValid/inLast   : message word stream, inBytes = valid bytes of last word
//   inReady                 : word accepted when inValid & inReady
//   outData/outValid/outLast: state block, last flag marks the final padded block
//   outReady                : consumer takes the block when outValid & outReady
// Build option: SHA3_KECCAK_PAD_EN selects the Keccak domain byte 0x01.
module sha3_padder #(
    parameter int RATE_LANES = 9,
    parameter int LANE_W     = 64
) (
    input  logic                          inClk,
    input  logic                          inRstN,
    input  logic [LANE_W-1:0]             inData,
    input  logic                          inValid,
    input  logic                          inLast,
    input  logic [3:0]                    inBytes,
    output logic                          inReady,
    output logic [sha3_pkg::STATE_W-1:0]  outData,
    output logic                          outValid,
    output logic                          outLast,
    input  logic                          outReady
);

    import sha3_pkg::*;

    localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_LANES - 1);

    pad_state_t                         state_reg;
    logic [CNT_W-1:0]                   lane_cnt_reg;
    logic [RATE_LANES-1:0][LANE_W-1:0]  block_reg;
    logic                               pad_pending_reg;
    logic                               in_ready_reg;
    logic                               out_valid_reg;
    logic                               out_last_reg;

    logic [3:0]                         nbytes;
    logic                               full_word;
    logic                               at_last_lane;
    logic                               accept;
    logic [LANE_W-1:0]                  padded_lane;
    logic [RATE_LANES-1:0][LANE_W-1:0]  pad_block;

    assign nbytes       = (inBytes > 4'd8) ? 4'd8 : inBytes;
    assign full_word    = (nbytes == 4'd8);
    assign at_last_lane = (lane_cnt_reg == LAST_LANE);
    assign accept       = inValid && in_ready_reg;

    sha3_pad_lane u_pad_lane (
        .lane       (inData),
        .nbytes     (nbytes),
        .last       (inLast),
        .final_lane (at_last_lane),
        .padded     (padded_lane)
    );

    // Pad-only block: used after a message that exactly filled a rate block.
    always_comb begin
        pad_block = '0;
        pad_block[0][7:0] = DOMAIN_BYTE;
        pad_block[RATE_LANES-1][LANE_W-1 -: 8] = pad_block[RATE_LANES-1][LANE_W-1 -: 8] ^ PAD_END;
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_reg       <= FILL;
            lane_cnt_reg    <= '0;
            block_reg       <= '0;
            pad_pending_reg <= 1'b0;
            in_ready_reg    <= 1'b1;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        block_reg[lane_cnt_reg] <= padded_lane;
                        if (inLast) begin
                            if (full_word && at_last_lane) begin
                                // Data fills the block exactly: padding goes out in PADX.
                                out_last_reg    <= 1'b0;
                                pad_pending_reg <= 1'b1;
                            end else begin
                                // Higher lanes are already zero, so plain writes
                                // act as the XOR the padding rule calls for.
                                if (!at_last_lane) begin
                                    block_reg[LAST_LANE][LANE_W-1 -: 8] <= PAD_END;
                                    if (full_word) begin
                                        block_reg[lane_cnt_reg + 1'b1][7:0] <= DOMAIN_BYTE;
                                    end
                                end
                                out_last_reg    <= 1'b1;
                                pad_pending_reg <= 1'b0;
                            end
                            state_reg     <= EMIT;
                            out_valid_reg <= 1'b1;
                            in_ready_reg  <= 1'b0;
                        end else if (at_last_lane) begin
                            state_reg       <= EMIT;
                            out_valid_reg   <= 1'b1;
                            out_last_reg    <= 1'b0;
                            pad_pending_reg <= 1'b0;
                            in_ready_reg    <= 1'b0;
                        end else begin
                            lane_cnt_reg <= lane_cnt_reg + 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (outReady) begin
                        lane_cnt_reg <= '0;
                        if (pad_pending_reg) begin
                            block_reg       <= pad_block;
                            out_last_reg    <= 1'b1;
                            pad_pending_reg <= 1'b0;
                            state_reg       <= PADX;
                        end else begin
                            block_reg     <= '0;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            state_reg     <= FILL;
                        end
                    end
                end

                PADX: begin
                    if (outReady) begin
                        block_reg     <= '0;
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= FILL;
                    end
                end

                default: begin
                    state_reg     <= FILL;
                    block_reg     <= '0;
                    lane_cnt_reg  <= '0;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign inReady  = in_ready_reg;
    assign outValid = out_valid_reg;
    assign outLast  = out_last_reg;
    assign outData  = {{(STATE_W - RATE_LANES*LANE_W){1'b0}}, block_reg};

endmodule

// File: tb/tb_sha3_padder.sv
module tb_sha3_padder;

    localparam int RB = 72; // rate bytes

`ifdef SHA3_KECCAK_PAD_EN
    localparam logic [7:0] DOM = 8'h01;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif

    logic          inClk;
    logic          inRstN;
    logic [63:0]   inData;
    logic          inValid;
    logic          inLast;
    logic [3:0]    inBytes;
    logic          inReady;
    logic [1599:0] outData;
    logic          outValid;
    logic          outLast;
    logic          outReady;

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 0; // 0: always ready, 1: random, 2: stalled

    logic [1599:0] got_data[$];
    bit            got_last[$];

    sha3_padder dut (
        .inClk    (inClk),
        .inRstN   (inRstN),
        .inData   (inData),
        .inValid  (inValid),
        .inLast   (inLast),
        .inBytes  (inBytes),
        .inReady  (inReady),
        .outData  (outData),
        .outValid (outValid),
        .outLast  (outLast),
        .outReady (outReady)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    // Block collector: records every block handed over to the consumer.
    always @(posedge inClk) begin
        if (inRstN && outValid && outReady) begin
            got_data.push_back(outData);
            got_last.push_back(outLast);
        end
    end

    // Consumer readiness driver.
    initial begin
        outReady = 1'b1;
        forever begin
            @(negedge inClk);
            if (rdy_mode == 1)      outReady = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 2) outReady = 1'b0;
            else                    outReady = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one word; returns at the negedge after it was accepted.
    task automatic put_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int guard = 0;
        while (!inReady && guard < 200) begin
            @(negedge inClk);
            guard++;
        end
        if (guard >= 200) chk("put_timeout", 1'b0, 1'b1);
        inValid = 1'b1;
        inData  = d;
        inLast  = last;
        inBytes = nb;
        @(negedge inClk);
        inValid = 1'b0;
        inData  = $urandom();
        inLast  = $urandom_range(0, 1);
        inBytes = 4'($urandom_range(0, 15));
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        int len = msg.size();
        int nwords = (len == 0) ? 1 : (len + 7) / 8;
        for (int w = 0; w < nwords; w++) begin
            logic [63:0] d;
            int nb;
            logic [3:0] nbf;
            nb = len - 8*w;
            if (nb > 8) nb = 8;
            d = {$urandom(), $urandom()}; // garbage beyond valid bytes must be masked
            for (int j = 0; j < nb; j++) d[8*j +: 8] = msg[8*w + j];
            if (w == nwords - 1) begin
                nbf = 4'(nb);
                if (nb == 8 && $urandom_range(0, 1) == 1) nbf = 4'($urandom_range(9, 15));
                put_word(d, 1'b1, nbf);
            end else begin
                put_word(d, 1'b0, 4'($urandom_range(0, 15)));
            end
        end
    endtask

    // Reference: standard pad10*1 on a byte array, split into 72-byte blocks.
    task automatic model(input logic [7:0] msg[$], output logic [1599:0] blks[$]);
        logic [7:0] p[$];
        p = msg;
        p.push_back(DOM);
        while (p.size() % RB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        blks.delete();
        for (int b = 0; b < p.size() / RB; b++) begin
            logic [1599:0] blk = '0;
            for (int j = 0; j < RB; j++) blk[8*j +: 8] = p[RB*b + j];
            blks.push_back(blk);
        end
    endtask

    task automatic run_msg(input string tag, input logic [7:0] msg[$]);
        logic [1599:0] exp_q[$];
        int guard = 0;
        got_data.delete();
        got_last.delete();
        model(msg, exp_q);
        send_msg(msg);
        while (got_data.size() < exp_q.size() && guard < 400) begin
            @(negedge inClk);
            guard++;
        end
        repeat (3) @(negedge inClk);
        chk({tag, "_count"}, 1600'(got_data.size()), 1600'(exp_q.size()));
        for (int b = 0; b < exp_q.size() && b < got_data.size(); b++) begin
            $display("txn %s len=%0d block=%0d last=%0b", tag, msg.size(), b, got_last[b]);
            chk($sformatf("%s_data%0d", tag, b), got_data[b], exp_q[b]);
            chk($sformatf("%s_last%0d", tag, b), 1600'(got_last[b]), 1600'(b == exp_q.size() - 1));
        end
    endtask

    initial begin
        logic [7:0] m[$];
        logic [1599:0] snap;
        logic [1599:0] exp_q[$];
        int guard;

        inRstN  = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        inLast  = 1'b0;
        inBytes = '0;
        repeat (3) @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);
        chk("rst_outValid", 1600'(outValid), 1600'(0));
        chk("rst_outLast",  1600'(outLast),  1600'(0));
        chk("rst_outData",  outData,         '0);
        chk("rst_inReady",  1600'(inReady),  1600'(1));

        // Empty message: single pad block.
        m.delete();
        run_msg("empty", m);

        // 4-byte message 0x53587B19.
        m = '{8'h19, 8'h7B, 8'h58, 8'h53};
        run_msg("four", m);
        if (got_data.size() > 0)
            chk("four_lane0", 1600'(got_data[0][63:0]), 1600'({24'h0, DOM, 32'h53587B19}));

        // 71 bytes: domain byte and end bit share byte 71.
        m.delete();
        for (int i = 0; i < 71; i++) m.push_back(8'($urandom()));
        run_msg("b71", m);
        if (got_data.size() > 0)
            chk("b71_byte71", 1600'(got_data[0][575:568]), 1600'(DOM ^ 8'h80));

        // 72 bytes: data block then pad-only block.
        m.delete();
        for (int i = 0; i < 72; i++) m.push_back(8'($urandom()));
        run_msg("b72", m);

        // 64 bytes: domain byte lands at the start of the last lane.
        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom()));
        run_msg("b64", m);

        // Random lengths with random consumer backpressure.
        rdy_mode = 1;
        for (int t = 0; t < 16; t++) begin
            m.delete();
            for (int i = 0; i < $urandom_range(0, 160); i++) m.push_back(8'($urandom()));
            run_msg($sformatf("rnd%0d", t), m);
        end
        rdy_mode = 0;
        @(negedge inClk);

        // Backpressure: block must hold for 5 stalled cycles and go out once.
        rdy_mode = 2;
        @(negedge inClk);
        got_data.delete();
        got_last.delete();
        m = '{8'hA1, 8'hB2, 8'hC3};
        model(m, exp_q);
        send_msg(m);
        chk("bp_valid_latency", 1600'(outValid), 1600'(1));
        snap = outData;
        for (int c = 0; c < 5; c++) begin
            @(negedge inClk);
            chk($sformatf("bp_stable%0d", c), outData, snap);
            chk($sformatf("bp_inready%0d", c), 1600'(inReady), 1600'(0));
            chk($sformatf("bp_valid%0d", c), 1600'(outValid), 1600'(1));
        end
        rdy_mode = 0;
        guard = 0;
        while (got_data.size() < 1 && guard < 50) begin
            @(negedge inClk);
            guard++;
        end
        repeat (3) @(negedge inClk);
        $display("txn backpressure blocks=%0d", got_data.size());
        chk("bp_count", 1600'(got_data.size()), 1600'(1));
        if (got_data.size() > 0) chk("bp_data", got_data[0], exp_q[0]);
        chk("bp_inready_after", 1600'(inReady), 1600'(1));

        // Reset after 4 accepted words of an unfinished message.
        for (int w = 0; w < 4; w++) put_word({$urandom(), $urandom()}, 1'b0, 4'd8);
        inRstN = 1'b0;
        #1;
        chk("mid_rst_outValid", 1600'(outValid), 1600'(0));
        repeat (2) @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);
        $display("txn reset_mid_message");
        chk("post_rst_outValid", 1600'(outValid), 1600'(0));
        chk("post_rst_inReady",  1600'(inReady),  1600'(1));
        m.delete();
        run_msg("empty_after_rst", m);
        if (got_data.size() > 0) begin
            chk("ear_byte0",  1600'(got_data[0][7:0]),     1600'(DOM));
            chk("ear_byte71", 1600'(got_data[0][575:568]), 1600'(8'h80));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha3_padder.md
# sha3_padder

Message absorber/padder for the SHA3-512 datapath. Accepts the message as a stream of 64-bit little-endian words, packs it into 576-bit rate blocks, applies SHA-3 pad10*1 with the domain suffix, and presents each result as a full 1600-bit state block (rate lanes plus zero capacity) to the permutation input (`cFun` `inData`). It is the producing end of the 1600-bit state interface that the permutation rounds consume.

## Interface
- `RATE_LANES`, default 9: lanes per rate block (9 = 576 bits, SHA3-512).
- `LANE_W`, default 64: lane width in bits; only 64 is supported.
- `inClk`, input, 1: clock; all state is updated on the rising edge.
- `inRstN`, input, 1: asynchronous, active-low reset.
- `inData`, input, 64: message word; byte j is at bits [8j+7:8j].
- `inValid`, input, 1: `inData`, `inLast` and `inBytes` are valid.
- `inLast`, input, 1: the current word is the final word of the message.
- `inBytes`, input, 4: count of valid bytes, 0..8. Only meaningful with `inLast`; non-last words always carry 8 bytes.
- `inReady`, output, 1: the padder accepts a word this cycle.
- `outData`, output, 1600: state block; lane i is at [64i+63:64i], bits [1599:576] are always 0.
- `outValid`, output, 1: `outData` holds a complete block.
- `outLast`, output, 1: the current block is the final (padded) block of the message.
- `outReady`, input, 1: the consumer takes the block this cycle.

## Operation
- A word is accepted when `inValid & inReady`. It is written into lane `laneCnt` (0..RATE_LANES-1).
- FSM states:
  - FILL: `inReady` = 1.
  - EMIT: `outValid` = 1, `inReady` = 0.
  - PADX: `outValid` = 1 while an extra pad-only block is pending.
- Non-last word at lane RATE_LANES-1 → EMIT with `outLast` = 0. On handshake, clear the block buffer, set `laneCnt` = 0 and return to FILL.
- Last word with `inBytes` < 8, or with `laneCnt` < RATE_LANES-1:
  - Bytes at index ≥ `inBytes` are masked to 0.
  - The domain byte is XORed at message byte offset k = 8·laneCnt + `inBytes`.
  - 0x80 is XORed at byte 71, so k = 71 gives 0x86.
  - Lanes above `laneCnt` are 0.
  - Next state is EMIT with `outLast` = 1.
- Last word with `inBytes` = 8 at lane RATE_LANES-1: EMIT the full block with `outLast` = 0. After the handshake go to PADX. The PADX block is 0 except byte 0 = domain byte and byte 71 = 0x80; it carries `outLast` = 1. After its handshake return to FILL.
- Empty message (`inLast` with `inBytes` = 0 at lane 0) produces a single pad block identical to the PADX block.
- `inBytes` > 8 is treated as 8.
- `inBytes` on non-last words is ignored.
- Reset at any point: state = FILL, `laneCnt` = 0, buffer = 0, `outValid` = 0, `outLast` = 0, `inReady` = 1 after release. Any partial message is discarded.

## Timing
- Reset values: `outValid` = 0, `outLast` = 0, `outData` = 0, `inReady` = 1.
- `outValid` rises 1 cycle after acceptance of a block-completing word or a last word.
- `outData` and `outLast` stay stable while `outValid & !outReady`.
- `inReady` = 0 whenever `outValid` = 1; there is no overlap of fill and emit.
- After the EMIT handshake, `inReady` is high on the next cycle. Sustained throughput is 1 block per RATE_LANES+1 cycles.
- PADX: `outValid` rises the cycle after the preceding EMIT handshake.
- `inReady`, `outValid` and `outLast` are registered outputs. `outData` comes straight from the buffer register.

## Configuration
- `SHA3_KECCAK_PAD_EN`:
  - Defined: domain byte = 0x01 (original Keccak padding). A single-byte remainder gives 0x81.
  - Undefined: domain byte = 0x06 (FIPS 202 SHA-3). A single-byte remainder gives 0x86.

## Structure
- `sha3_pkg` holds:
  - Constants `STATE_W` = 1600, `LANE_W` = 64, `SHA3_512_RATE_LANES` = 9, `PAD_END` = 8'h80.
  - The domain byte constant, selected by the macro.
  - The FSM state enum (FILL, EMIT, PADX).
- Sub-module `sha3_pad_lane` is combinational. It takes a lane, `inBytes`, the last flag and the is-final-lane flag, and returns the masked and padded lane. It is instantiated once on the incoming word path.

## Test plan
- Empty message: `inLast`, `inBytes` = 0 → one block with `outData`[7:0] = 0x06, [575:568] = 0x80, all else 0, `outLast` = 1.
- 4-byte message 0x53587B19 (`inBytes` = 4) → lane 0 = 0x0000000653587B19, byte 71 = 0x80, `outLast` = 1.
- 71-byte message (8 full words, then a last word with `inBytes` = 7) → byte 71 = 0x86, one block, `outLast` = 1.
- 72-byte message → first block carries the data with `outLast` = 0, then a PADX block (0x06 at byte 0, 0x80 at byte 71) with `outLast` = 1.
- Backpressure: hold `outReady` = 0 for 5 cycles with `outValid` = 1 → `outData` unchanged, `inReady` = 0 throughout, and the block is accepted exactly once.
- Assert `inRstN` = 0 after 4 accepted words → `outValid` = 0 and `inReady` = 1 after release. A new empty message then yields the 0x06/0x80 block.
- With `SHA3_KECCAK_PAD_EN` defined, the empty message gives byte 0 = 0x01 and the 71-byte message gives byte 71 = 0x81.
